// File: rtl/snake_body_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// snake_body_scheduler_pkg
// Shared types and helpers for the snake body scheduler.
//   GAME_WIDTH / GAME_HEIGHT : playfield size in tiles (coordinate widths
//                              are derived from these, arithmetic wraps)
//   dir_t                    : 2-bit movement direction, opposite = bit 0 flip
//   scan_state_t             : body scan FSM states
//   dir_opposite / step_x / step_y : direction and coordinate helpers
// ---------------------------------------------------------------------------
package snake_body_scheduler_pkg;

    localparam int unsigned GAME_WIDTH  = 32;
    localparam int unsigned GAME_HEIGHT = 16;
    localparam int unsigned X_W         = $clog2(GAME_WIDTH);
    localparam int unsigned Y_W         = $clog2(GAME_HEIGHT);

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_UP    = 2'd3
    } dir_t;

    typedef enum logic {
        ST_EMIT   = 1'b0,
        ST_UPDATE = 1'b1
    } scan_state_t;

    function automatic dir_t dir_opposite(input dir_t d);
        return dir_t'(d ^ 2'b01);
    endfunction

    function automatic logic [X_W-1:0] step_x(input logic [X_W-1:0] x, input dir_t d);
        case (d)
            DIR_RIGHT: step_x = x + X_W'(1);
            DIR_LEFT:  step_x = x - X_W'(1);
            default:   step_x = x;
        endcase
    endfunction

    function automatic logic [Y_W-1:0] step_y(input logic [Y_W-1:0] y, input dir_t d);
        case (d)
            DIR_DOWN: step_y = y + Y_W'(1);
            DIR_UP:   step_y = y - Y_W'(1);
            default:  step_y = y;
        endcase
    endfunction

endpackage

// File: rtl/snake_body_scheduler_dir_ring.sv
// ---------------------------------------------------------------------------
// snake_dir_ring
// Circular store of per-segment tail-ward directions. Segment i lives at
// ring[rd_ptr + i]; a push writes the new head entry in front of rd_ptr and
// moves rd_ptr back by one, so the old tail entry silently falls off when the
// length does not grow.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_init       : synchronous bulk init (all entries LEFT, pointer 0)
//   i_push       : write i_push_dir at the front, decrement pointer
//   i_push_dir   : direction written for the new head segment
//   i_idx        : segment index to read
//   o_rd_dir     : direction stored for segment i_idx (combinational)
// ---------------------------------------------------------------------------
module snake_dir_ring
    import snake_body_scheduler_pkg::*;
#(
    parameter  int unsigned MAX_LEN = 64,
    localparam int unsigned PW      = $clog2(MAX_LEN)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_init,
    input  logic          i_push,
    input  logic [1:0]    i_push_dir,
    input  logic [PW-1:0] i_idx,
    output logic [1:0]    o_rd_dir
);

    dir_t          r_ring [MAX_LEN];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] w_front;
    logic [PW-1:0] w_rd_addr;

    assign w_front   = r_rd_ptr - PW'(1);
    assign w_rd_addr = r_rd_ptr + i_idx;
    assign o_rd_dir  = r_ring[w_rd_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            for (int unsigned i = 0; i < MAX_LEN; i++) r_ring[i] <= DIR_LEFT;
        end else if (i_init) begin
            r_rd_ptr <= '0;
            for (int unsigned i = 0; i < MAX_LEN; i++) r_ring[i] <= DIR_LEFT;
        end else if (i_push) begin
            r_rd_ptr         <= w_front;
            r_ring[w_front]  <= dir_t'(i_push_dir);
        end
    end

endmodule

// File: rtl/snake_body_scheduler.sv
// ---------------------------------------------------------------------------
// snake_body_scheduler
// Owns the snake body (head position + direction ring) and time-shares it
// between the game engine and the VGA renderer. The body is replayed
// head-to-tail, one segment per clock, in back-to-back passes; a pending
// game update is applied in a single UPDATE cycle between passes so the
// renderer never sees a half-updated body.
// Optional feature macro: SNAKE_SELF_HIT_EN (adds output self_hit).
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   game_rst_n        : synchronous active-low game restart
//   upd_req/grow/dir  : game update request (held until upd_ack)
//   upd_ack           : one-cycle pulse, update applied at this edge
//   full              : length == MAX_LEN
//   snake_head_x/y    : current head tile
//   snake_x/y/dir     : streamed segment tile and its tail-ward direction
//   snake_first/last  : segment is head / tail
//   snake_valid       : stream slot carries a segment
//   self_hit          : (SNAKE_SELF_HIT_EN) head overlapped body last pass
// ---------------------------------------------------------------------------
module snake_body_scheduler
    import snake_body_scheduler_pkg::*;
#(
    parameter int unsigned MAX_LEN  = 64,
    parameter int unsigned INIT_LEN = 3,
    parameter int unsigned INIT_X   = 5,
    parameter int unsigned INIT_Y   = 7
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           game_rst_n,
    input  logic           upd_req,
    input  logic           upd_grow,
    input  logic [1:0]     upd_dir,
    output logic           upd_ack,
    output logic           full,
    output logic [X_W-1:0] snake_head_x,
    output logic [Y_W-1:0] snake_head_y,
    output logic [X_W-1:0] snake_x,
    output logic [Y_W-1:0] snake_y,
    output logic [1:0]     snake_dir,
    output logic           snake_first,
    output logic           snake_last,
`ifdef SNAKE_SELF_HIT_EN
    output logic           self_hit,
`endif
    output logic           snake_valid
);

    localparam int unsigned IW = $clog2(MAX_LEN);
    localparam int unsigned LW = IW + 1;

    localparam logic [X_W-1:0] C_INIT_X   = X_W'(INIT_X);
    localparam logic [Y_W-1:0] C_INIT_Y   = Y_W'(INIT_Y);
    localparam logic [LW-1:0]  C_INIT_LEN = LW'(INIT_LEN);
    localparam logic [LW-1:0]  C_MAX_LEN  = LW'(MAX_LEN);

    scan_state_t    r_state;
    scan_state_t    w_state_nxt;

    logic [IW-1:0]  r_idx;
    logic [LW-1:0]  r_len;
    logic [X_W-1:0] r_cur_x;
    logic [Y_W-1:0] r_cur_y;
    logic [X_W-1:0] r_head_x;
    logic [Y_W-1:0] r_head_y;

    logic [X_W-1:0] r_seg_x;
    logic [Y_W-1:0] r_seg_y;
    logic [1:0]     r_seg_dir;
    logic           r_first;
    logic           r_last;
    logic           r_valid;
    logic           r_ack;

    logic [X_W-1:0] w_x_nxt;
    logic [Y_W-1:0] w_y_nxt;
    logic [1:0]     w_dir_nxt;
    logic           w_first_nxt;
    logic           w_last_nxt;
    logic           w_valid_nxt;
    logic           w_ack_nxt;

    logic [1:0]     w_rd_dir;
    logic           w_is_last;
    logic           w_full;
    logic           w_push;
    logic [X_W-1:0] w_upd_head_x;
    logic [Y_W-1:0] w_upd_head_y;
    dir_t           w_front_dir;

    assign w_is_last    = ({1'b0, r_idx} == (r_len - LW'(1)));
    assign w_full       = (r_len == C_MAX_LEN);
    assign w_push       = (r_state == ST_UPDATE) && game_rst_n;
    assign w_upd_head_x = step_x(r_head_x, dir_t'(upd_dir));
    assign w_upd_head_y = step_y(r_head_y, dir_t'(upd_dir));
    assign w_front_dir  = dir_opposite(dir_t'(upd_dir));

    snake_dir_ring #(
        .MAX_LEN (MAX_LEN)
    ) u_ring (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_init     (!game_rst_n),
        .i_push     (w_push),
        .i_push_dir (w_front_dir),
        .i_idx      (r_idx),
        .o_rd_dir   (w_rd_dir)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_EMIT;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic; restart always lands in EMIT
    always_comb begin
        w_state_nxt = r_state;
        if (!game_rst_n) begin
            w_state_nxt = ST_EMIT;
        end else begin
            case (r_state)
                ST_EMIT:   if (w_is_last && upd_req) w_state_nxt = ST_UPDATE;
                ST_UPDATE: w_state_nxt = ST_EMIT;
                default:   w_state_nxt = ST_EMIT;
            endcase
        end
    end

    // Output logic: next values of the registered stream outputs
    always_comb begin
        w_x_nxt     = '0;
        w_y_nxt     = '0;
        w_dir_nxt   = '0;
        w_first_nxt = 1'b0;
        w_last_nxt  = 1'b0;
        w_valid_nxt = 1'b0;
        w_ack_nxt   = 1'b0;
        if (game_rst_n) begin
            case (r_state)
                ST_EMIT: begin
                    w_x_nxt     = r_cur_x;
                    w_y_nxt     = r_cur_y;
                    w_dir_nxt   = w_rd_dir;
                    w_first_nxt = (r_idx == '0);
                    w_last_nxt  = w_is_last;
                    w_valid_nxt = 1'b1;
                end
                ST_UPDATE: w_ack_nxt = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_x   <= '0;
            r_seg_y   <= '0;
            r_seg_dir <= '0;
            r_first   <= 1'b0;
            r_last    <= 1'b0;
            r_valid   <= 1'b0;
            r_ack     <= 1'b0;
        end else begin
            r_seg_x   <= w_x_nxt;
            r_seg_y   <= w_y_nxt;
            r_seg_dir <= w_dir_nxt;
            r_first   <= w_first_nxt;
            r_last    <= w_last_nxt;
            r_valid   <= w_valid_nxt;
            r_ack     <= w_ack_nxt;
        end
    end

    // Scan walker and body state. r_cur tracks the position of segment r_idx,
    // stepped by that segment's ring entry as the scan advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head_x <= C_INIT_X;
            r_head_y <= C_INIT_Y;
            r_cur_x  <= C_INIT_X;
            r_cur_y  <= C_INIT_Y;
            r_len    <= C_INIT_LEN;
            r_idx    <= '0;
        end else if (!game_rst_n) begin
            r_head_x <= C_INIT_X;
            r_head_y <= C_INIT_Y;
            r_cur_x  <= C_INIT_X;
            r_cur_y  <= C_INIT_Y;
            r_len    <= C_INIT_LEN;
            r_idx    <= '0;
        end else begin
            case (r_state)
                ST_EMIT: begin
                    if (w_is_last) begin
                        r_idx   <= '0;
                        r_cur_x <= r_head_x;
                        r_cur_y <= r_head_y;
                    end else begin
                        r_idx   <= r_idx + IW'(1);
                        r_cur_x <= step_x(r_cur_x, dir_t'(w_rd_dir));
                        r_cur_y <= step_y(r_cur_y, dir_t'(w_rd_dir));
                    end
                end
                ST_UPDATE: begin
                    r_head_x <= w_upd_head_x;
                    r_head_y <= w_upd_head_y;
                    r_cur_x  <= w_upd_head_x;
                    r_cur_y  <= w_upd_head_y;
                    r_idx    <= '0;
                    // A grow request at full length degrades to a move
                    if (upd_grow && !w_full) r_len <= r_len + LW'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef SNAKE_SELF_HIT_EN
    logic r_hit_acc;
    logic r_self_hit;
    logic w_hit_now;

    assign w_hit_now = (r_idx != '0) && (r_cur_x == r_head_x) && (r_cur_y == r_head_y);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_acc  <= 1'b0;
            r_self_hit <= 1'b0;
        end else if (!game_rst_n) begin
            r_hit_acc  <= 1'b0;
            r_self_hit <= 1'b0;
        end else if (r_state == ST_EMIT) begin
            if (w_is_last) begin
                r_self_hit <= r_hit_acc | w_hit_now;
                r_hit_acc  <= 1'b0;
            end else begin
                r_hit_acc  <= r_hit_acc | w_hit_now;
            end
        end
    end

    assign self_hit = r_self_hit;
`endif

    assign upd_ack      = r_ack;
    assign full         = w_full;
    assign snake_head_x = r_head_x;
    assign snake_head_y = r_head_y;
    assign snake_x      = r_seg_x;
    assign snake_y      = r_seg_y;
    assign snake_dir    = r_seg_dir;
    assign snake_first  = r_first;
    assign snake_last   = r_last;
    assign snake_valid  = r_valid;

endmodule

// File: doc/snake_body_scheduler.md
Name: snake_body_scheduler

Overview:
- Owns the snake body store: head position plus a circular buffer of 2-bit segment directions.
- Time-shares that store between two users:
  - the game engine, which moves or grows the snake;
  - the VGA renderer, which needs one body segment per clock, streamed head-to-tail.
- Replays the body as a continuous segment stream on the renderer's snake_* inputs.
- Admits game updates only at the pass boundary, so the renderer never sees a half-updated body.

Parameters:
- MAX_LEN, 64, body store depth in segments (power of two).
- INIT_LEN, 3, length after reset and after game restart (2..MAX_LEN).
- INIT_X, 5, head tile x after reset and after restart.
- INIT_Y, 7, head tile y after reset and after restart.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- game_rst_n  in  1  synchronous active-low game restart
- upd_req  in  1  game requests a body update; held until upd_ack
- upd_grow  in  1  1 = push only (grow); 0 = push and pop (move)
- upd_dir  in  2  head movement direction
- upd_ack  out  1  one-cycle pulse; update applied at this edge
- full  out  1  length == MAX_LEN
- snake_head_x  out  5  current head tile x
- snake_head_y  out  4  current head tile y
- snake_x  out  5  streamed segment tile x
- snake_y  out  4  streamed segment tile y
- snake_dir  out  2  direction from this segment toward the next (tail-ward) one
- snake_first  out  1  segment is the head
- snake_last  out  1  segment is the tail
- snake_valid  out  1  stream slot carries a segment

Behaviour:
- Direction encoding: 0 right (+x), 1 left, 2 down (+y), 3 up. Opposite direction = bit 0 inverted.
- Store layout:
  - ring[rd_ptr + i] holds the tail-ward direction of segment i, i = 0..len-1.
  - The tail entry's value is don't-care; the renderer masks it with snake_last.
- Coordinate arithmetic is modulo field width (5 bits x, 4 bits y); no clamping. Collision and border checks belong to the game engine.
- Reset (rst_n low) and restart (game_rst_n low at a clock edge) set:
  - head = (INIT_X, INIT_Y), len = INIT_LEN, all ring entries = 1 (body extends left);
  - scan in state EMIT, index 0;
  - all outputs 0, except snake_head_x/y = INIT.
  - Restart overrides a pending upd_req; no ack is issued for that request.
- Scan FSM states EMIT and UPDATE; outputs are registered.
  - EMIT:
    - Each cycle, drive segment i: snake_valid=1, first = (i==0), last = (i==len-1), position, and dir = ring entry.
    - Segment i+1 position = segment i position stepped by its dir.
    - After the last segment: go to UPDATE if upd_req is high, else restart at i=0 on the next cycle (back-to-back passes, no gap).
  - UPDATE (exactly one cycle):
    - snake_valid=0, upd_ack=1.
    - head += step(upd_dir).
    - rd_ptr decrements; the new front entry = opposite(upd_dir).
    - len += 1 if upd_grow, else len unchanged (tail dropped implicitly).
    - Next state EMIT, i=0; the new head streams the cycle after ack.
- Full: upd_grow with full=1 is executed as a move (len unchanged); ack is still issued.
- upd_req latency: worst case len+1 cycles from assertion to ack.
- upd_req deasserted before its ack means no update; it is not latched.
- snake_head_x/y change only on UPDATE edges, restart and reset.

Optional Feature:
- Macro SNAKE_SELF_HIT_EN.
- When defined, add output self_hit (1 bit, reset 0):
  - during each pass, compare every segment with i>=1 against the head;
  - at the pass's last segment, register OR(matches) into self_hit;
  - hold until the next pass ends; clear on restart.
- When undefined: no port, no comparators.

Decomposition:
- Shared package (alongside GAME_WIDTH/GAME_HEIGHT):
  - dir_t enum (DIR_RIGHT, DIR_LEFT, DIR_DOWN, DIR_UP);
  - function dir_opposite;
  - function step_x / step_y.
- Sub-module snake_dir_ring: MAX_LEN x 2-bit register array, with:
  - read port at rd_ptr+index;
  - write-at-front / pointer decrement;
  - bulk init on restart.

Test Plan:
- Reset, no requests → stream repeats (5,7,dir1,first),(4,7),(3,7,last), valid each cycle, 3-cycle period.
- Move: upd_req with dir 2 held during the head slot → ack after (3,7,last); next pass (5,8,dir3),(5,7,dir1),(4,7,last); len stays 3.
- Grow: upd_grow=1, dir 0 → head (6,7); next pass 4 segments ending (3,7); full=0.
- Fill to MAX_LEN via grows → full=1; a further grow acts as a move, len stays 64, ack still pulses.
- game_rst_n low mid-pass with upd_req high → no ack; next cycle restarts the INIT stream.
- SNAKE_SELF_HIT_EN: moves right, down, left, up on a length-5 snake → self_hit=1 at the end of the following pass.
